// File: rtl/mul_func_unit_pkg.sv
// Shared widths, issue/CDB payload types and multiply opcode decode for the
// out-of-order core's multiply functional unit.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P  = 16;
  localparam int NUM_PHYS_REG = 64;
  localparam int ROB_ENTRY    = 16;
  localparam int MUL_FU       = 2;

  localparam int PREG_W    = $clog2(NUM_PHYS_REG);
  localparam int ROB_IDX_W = $clog2(ROB_ENTRY);
  localparam int OPC_W     = 7;

  localparam logic [OPC_W-1:0] OPC_MUL   = 7'h10;
  localparam logic [OPC_W-1:0] OPC_MULH  = 7'h11;
  localparam logic [OPC_W-1:0] OPC_MULHU = 7'h13;

  typedef enum logic [1:0] {
    MOP_NONE = 2'd0,
    MOP_LO   = 2'd1,
    MOP_HI   = 2'd2
  } mul_op_e;

  typedef struct packed {
    logic [OPC_W-1:0]       opcode;
    logic [WORD_SIZE_P-1:0] source_1_data;
    logic [WORD_SIZE_P-1:0] source2_imm_data;
    logic [PREG_W-1:0]      dest_id;
    logic [ROB_IDX_W-1:0]   rob_dest;
    logic                   w_v;
  } issued_instruction_t;

  typedef struct packed {
    logic [PREG_W-1:0]      dest;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

  typedef struct packed {
    logic [PREG_W-1:0]    dest;
    logic [ROB_IDX_W-1:0] rob;
    logic                 w_v;
    mul_op_e              op;
  } mul_meta_t;

  // Unknown opcodes still retire, but with a zero result.
  function automatic mul_op_e decode_mul_op(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_MUL:             return MOP_LO;
      OPC_MULH, OPC_MULHU: return MOP_HI;
      default:             return MOP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mul_func_unit_if.sv
// Issue-lane input and CDB/ROB completion outputs of the multiply unit.
interface mul_func_unit_if;
  import Purple_Jade_pkg::*;

  issued_instruction_t  instruction_i;
  logic                 valid_i;
  logic                 flush_i;
  CDB_t                 cdb_o;
  logic                 cdb_v_o;
  logic                 rob_done_v_o;
  logic [ROB_IDX_W-1:0] rob_idx_o;

  modport master (
    output instruction_i, valid_i, flush_i,
    input  cdb_o, cdb_v_o, rob_done_v_o, rob_idx_o
  );

  modport slave (
    input  instruction_i, valid_i, flush_i,
    output cdb_o, cdb_v_o, rob_done_v_o, rob_idx_o
  );

endinterface

// File: rtl/mul_func_unit_pipe_core.sv
// Full-width multiplier split into MUL_STAGES-1 register stages; each stage
// adds the partial product of one slice of operand B into the accumulator.
module mul_pipe_core #(
  parameter int MUL_STAGES = 3,
  parameter int WIDTH_P    = 16
) (
  input  logic                   i_clk,
  input  logic [WIDTH_P-1:0]     i_op_a,
  input  logic [WIDTH_P-1:0]     i_op_b,
  input  logic                   i_signed,
  output logic [2*WIDTH_P-1:0]   o_product
);

  localparam int N  = MUL_STAGES - 1;
  localparam int PW = 2 * WIDTH_P;
  localparam int CH = (PW + N - 1) / N;
  localparam int BW = N * CH;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_sx;
  logic [BW-1:0] w_b_ext;

  // Extending both operands to 2W makes the low 2W product bits exact for
  // signed and unsigned operation alike.
  assign w_a_ext = {{WIDTH_P{i_signed & i_op_a[WIDTH_P-1]}}, i_op_a};
  assign w_b_sx  = {{WIDTH_P{i_signed & i_op_b[WIDTH_P-1]}}, i_op_b};
  assign w_b_ext = BW'(w_b_sx);

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int BIN_W = BW - k * CH;

    logic [PW-1:0]    w_a_in;
    logic [BIN_W-1:0] w_b_in;
    logic [PW-1:0]    w_acc_in;
    logic [PW-1:0]    w_slice;
    logic [PW-1:0]    r_acc;

    if (k == 0) begin : g_head
      assign w_a_in   = w_a_ext;
      assign w_b_in   = w_b_ext;
      assign w_acc_in = '0;
    end else begin : g_tail
      assign w_a_in   = g_stage[k-1].g_fwd.r_a;
      assign w_b_in   = g_stage[k-1].g_fwd.r_b;
      assign w_acc_in = g_stage[k-1].r_acc;
    end

    assign w_slice = PW'(w_b_in[CH-1:0]);

    always_ff @(posedge i_clk) begin
      r_acc <= w_acc_in + (w_a_in * w_slice);
    end

    // A is pre-shifted so the next slice's partial product lands in place.
    if (k < N - 1) begin : g_fwd
      logic [PW-1:0]       r_a;
      logic [BIN_W-CH-1:0] r_b;

      always_ff @(posedge i_clk) begin
        r_a <= w_a_in << CH;
        r_b <= w_b_in[BIN_W-1:CH];
      end
    end
  end

  assign o_product = g_stage[N-1].r_acc;

endmodule

// File: rtl/mul_func_unit.sv
// Fixed-latency, never-stalling multiply unit fed by the issue table; carries
// instruction metadata alongside the multiplier and registers CDB/ROB outputs.
module mul_func_unit #(
  parameter int MUL_STAGES  = 3,
  parameter int WORD_SIZE_P = Purple_Jade_pkg::WORD_SIZE_P
) (
  input  logic           clk_i,
  input  logic           reset_i,
  mul_func_unit_if.slave bus
);
  import Purple_Jade_pkg::*;

  localparam int LAST = MUL_STAGES - 2;

  logic                     r_v    [MUL_STAGES-1];
  mul_meta_t                r_meta [MUL_STAGES-1];
  logic [2*WORD_SIZE_P-1:0] w_product;
  logic                     w_signed;
  logic                     w_last_v;
  mul_meta_t                w_last;
  logic [WORD_SIZE_P-1:0]   w_result;

  CDB_t                     r_cdb;
  logic                     r_cdb_v;
  logic                     r_done;
  logic [ROB_IDX_W-1:0]     r_rob_idx;

  assign w_signed = (bus.instruction_i.opcode != OPC_MULHU);

  mul_pipe_core #(
    .MUL_STAGES (MUL_STAGES),
    .WIDTH_P    (WORD_SIZE_P)
  ) u_core (
    .i_clk     (clk_i),
    .i_op_a    (bus.instruction_i.source_1_data),
    .i_op_b    (bus.instruction_i.source2_imm_data),
    .i_signed  (w_signed),
    .o_product (w_product)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i || bus.flush_i) begin
      for (int k = 0; k < MUL_STAGES - 1; k++) r_v[k] <= 1'b0;
    end else begin
      r_v[0] <= bus.valid_i;
      for (int k = 1; k < MUL_STAGES - 1; k++) r_v[k] <= r_v[k-1];
    end
  end

  // Payload travels unconditionally; only the valids are killed.
  always_ff @(posedge clk_i) begin
    r_meta[0] <= '{dest: bus.instruction_i.dest_id,
                   rob:  bus.instruction_i.rob_dest,
                   w_v:  bus.instruction_i.w_v,
                   op:   decode_mul_op(bus.instruction_i.opcode)};
    for (int k = 1; k < MUL_STAGES - 1; k++) r_meta[k] <= r_meta[k-1];
  end

  assign w_last_v = r_v[LAST];
  assign w_last   = r_meta[LAST];

  always_comb begin
    w_result = '0;
    case (w_last.op)
      MOP_LO:  w_result = w_product[WORD_SIZE_P-1:0];
      MOP_HI:  w_result = w_product[2*WORD_SIZE_P-1:WORD_SIZE_P];
      default: w_result = '0;
    endcase
  end

  // Idle CDB is driven to zero so tag 0 never matches a waiting source.
  always_ff @(posedge clk_i) begin
    if (!reset_i || bus.flush_i) begin
      r_cdb     <= '0;
      r_cdb_v   <= 1'b0;
      r_done    <= 1'b0;
      r_rob_idx <= '0;
    end else begin
      r_done    <= w_last_v;
      r_cdb_v   <= w_last_v & w_last.w_v;
      r_rob_idx <= w_last_v ? w_last.rob : '0;
      if (w_last_v && w_last.w_v) begin
        r_cdb <= '{dest: w_last.dest, result: w_result};
      end else begin
        r_cdb <= '0;
      end
    end
  end

  assign bus.cdb_o        = r_cdb;
  assign bus.cdb_v_o      = r_cdb_v;
  assign bus.rob_done_v_o = r_done;
  assign bus.rob_idx_o    = r_rob_idx;

endmodule

// File: tb/tb_mul_func_unit.sv
// Directed bench for mul_func_unit: a scoreboard queue holds the expected
// completion for each accept, tagged with the cycle it must appear in.
module tb_mul_func_unit;
  import Purple_Jade_pkg::*;

  localparam int MUL_STAGES = 3;
  localparam int W          = WORD_SIZE_P;

  typedef struct {
    int                   due;
    logic                 cdb_v;
    logic                 done;
    logic [ROB_IDX_W-1:0] rob;
    CDB_t                 cdb;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_i;

  mul_func_unit_if bus ();

  mul_func_unit #(
    .MUL_STAGES  (MUL_STAGES),
    .WORD_SIZE_P (W)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  exp_t             q[$];
  int               checks    = 0;
  int               errors    = 0;
  int               cyc       = 0;
  logic             kill_prev = 1'b1;
  logic [OPC_W-1:0] ops [3]   = '{OPC_MUL, OPC_MULH, OPC_MULHU};

  function automatic issued_instruction_t mk(input logic [OPC_W-1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input int dest, input int rob,
                                             input logic wv);
    issued_instruction_t i;
    i.opcode           = op;
    i.source_1_data    = a;
    i.source2_imm_data = b;
    i.dest_id          = PREG_W'(dest);
    i.rob_dest         = ROB_IDX_W'(rob);
    i.w_v              = wv;
    return i;
  endfunction

  function automatic exp_t model(input issued_instruction_t ins, input int due);
    exp_t                 e;
    logic signed [2*W-1:0] sa, sb, ps;
    logic [2*W-1:0]        pu;
    logic [W-1:0]          res;
    sa = $signed(ins.source_1_data);
    sb = $signed(ins.source2_imm_data);
    ps = sa * sb;
    pu = {{W{1'b0}}, ins.source_1_data} * {{W{1'b0}}, ins.source2_imm_data};
    case (ins.opcode)
      OPC_MUL:   res = ps[W-1:0];
      OPC_MULH:  res = ps[2*W-1:W];
      OPC_MULHU: res = pu[2*W-1:W];
      default:   res = '0;
    endcase
    e.due   = due;
    e.done  = 1'b1;
    e.cdb_v = ins.w_v;
    e.rob   = ins.rob_dest;
    if (ins.w_v) begin
      e.cdb.dest   = ins.dest_id;
      e.cdb.result = res;
    end else begin
      e.cdb = '0;
    end
    return e;
  endfunction

  // Check the outputs of the current cycle, then drive the next edge's inputs.
  task automatic step(input logic rst_n, input logic v, input logic fl,
                      input issued_instruction_t ins);
    exp_t e;
    @(negedge clk_i);
    cyc++;
    e = '{due: 0, cdb_v: 1'b0, done: 1'b0, rob: '0, cdb: '0};
    if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();

    checks++;
    assert (bus.rob_done_v_o === e.done) else begin
      errors++;
      $error("FAIL rob_done cyc %0d got %b exp %b", cyc, bus.rob_done_v_o, e.done);
    end
    checks++;
    assert (bus.cdb_v_o === e.cdb_v) else begin
      errors++;
      $error("FAIL cdb_v cyc %0d got %b exp %b", cyc, bus.cdb_v_o, e.cdb_v);
    end
    checks++;
    assert (bus.cdb_o === e.cdb) else begin
      errors++;
      $error("FAIL cdb cyc %0d got %h exp %h", cyc, bus.cdb_o, e.cdb);
    end
    if (e.done || kill_prev) begin
      checks++;
      assert (bus.rob_idx_o === e.rob) else begin
        errors++;
        $error("FAIL rob_idx cyc %0d got %0d exp %0d", cyc, bus.rob_idx_o, e.rob);
      end
    end

    kill_prev         = !rst_n || fl;
    reset_i           = rst_n;
    bus.valid_i       = v;
    bus.flush_i       = fl;
    bus.instruction_i = ins;
    if (kill_prev) q.delete();
    else if (v) q.push_back(model(ins, cyc + MUL_STAGES));
  endtask

  issued_instruction_t idle;
  logic [W-1:0]        ra, rb;

  initial begin
    idle              = mk(7'h00, '0, '0, 0, 0, 1'b0);
    reset_i           = 1'b0;
    bus.valid_i       = 1'b1;
    bus.flush_i       = 1'b0;
    bus.instruction_i = mk(OPC_MUL, 16'h0003, 16'h0005, 12, 4, 1'b1);

    // Reset held with valid traffic: nothing may ever broadcast.
    repeat (3) step(1'b0, 1'b1, 1'b0, mk(OPC_MUL, 16'h0003, 16'h0005, 12, 4, 1'b1));

    // First accept on the first edge out of reset.
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0007, 16'hFFFD, 5, 2, 1'b1));
    repeat (3) step(1'b1, 1'b0, 1'b0, idle);

    // High halves and an unrecognised opcode.
    step(1'b1, 1'b1, 1'b0, mk(OPC_MULH,  16'h8000, 16'h8000, 3, 3, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MULHU, 16'h8000, 16'h8000, 4, 4, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MULH,  16'hFFFF, 16'hFFFF, 6, 5, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MULHU, 16'hFFFF, 16'hFFFF, 7, 6, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(7'h33,     16'h0005, 16'h0006, 8, 9, 1'b1));
    repeat (3) step(1'b1, 1'b0, 1'b0, idle);

    // Back-to-back stream.
    for (int i = 1; i <= 10; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      step(1'b1, 1'b1, 1'b0, mk(ops[i % 3], ra, rb, i, i, 1'b1));
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, idle);

    // Flush kills A, B and C; D goes through.
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0011, 16'h0002, 20, 1, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0012, 16'h0003, 21, 2, 1'b1));
    step(1'b1, 1'b1, 1'b1, mk(OPC_MUL, 16'h0013, 16'h0004, 22, 3, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0014, 16'h0005, 23, 4, 1'b1));
    repeat (4) step(1'b1, 1'b0, 1'b0, idle);

    // Completion without register write.
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0003, 16'h0004, 9, 7, 1'b0));
    repeat (3) step(1'b1, 1'b0, 1'b0, idle);

    // Reset mid-flight discards everything in the pipe.
    step(1'b1, 1'b1, 1'b0, mk(OPC_MUL, 16'h0021, 16'h0003, 30, 10, 1'b1));
    step(1'b1, 1'b1, 1'b0, mk(OPC_MULH, 16'h7FFF, 16'h7FFF, 31, 11, 1'b1));
    step(1'b0, 1'b0, 1'b0, idle);
    repeat (5) step(1'b1, 1'b0, 1'b0, idle);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain got %0d pending exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_func_unit.md
# mul_func_unit

Pipelined integer multiply functional unit sitting directly downstream of the issue table: it consumes one issued multiply-class instruction per cycle from the issue table's multiply `valid_o` lane. It produces a result on its common-data-bus (CDB) slot plus a ROB completion pulse after a fixed latency. The issue table has no back-pressure from functional units, so this block accepts unconditionally every cycle and never stalls.

## Interface
- `MUL_STAGES`, default 3: total cycles from accept to CDB broadcast; legal range 2–6.
- `WORD_SIZE_P`, default from package: operand and result width.
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous, active-low; the block is in reset while `reset_i`==0 at a rising edge.
- `instruction_i` in `issued_instruction_t`: issued instruction. Uses `opcode`, `source_1_data`, `source2_imm_data`, `dest_id`, `rob_dest`, `w_v`.
- `valid_i` in 1: issue table `valid_o[MUL_FU]`. Always accepted.
- `flush_i` in 1: mispredict recovery; kills all in-flight work.
- `cdb_o` out `CDB_t`: `dest` = physical destination, `result` = product word.
- `cdb_v_o` out 1: `cdb_o` carries a real broadcast this cycle.
- `rob_done_v_o` out 1: completion pulse to the ROB.
- `rob_idx_o` out `$clog2(ROB_ENTRY)`: ROB entry completing.

## Operation
- Opcodes:
  - MUL: low `WORD_SIZE_P` bits of the signed×signed product.
  - MULH: high half, signed×signed.
  - MULHU: high half, unsigned×unsigned.
  - Any other opcode arriving with `valid_i`: result 0, still completes.
- The product is computed at full `2*WORD_SIZE_P` width. Partial products are split across stages 1..`MUL_STAGES-1`; the final stage selects the half and registers the outputs.
- Each stage holds: valid, `dest_id`, `rob_dest`, `w_v`, op select, partial state.
- Stage 0 valid loads `valid_i & ~flush_i`.
- Each cycle, stage k+1 loads stage k. No bubbles are collapsed and no stall path exists.
- Output stage valid:
  - `rob_done_v_o` = 1 for every surviving instruction.
  - `cdb_v_o` = 1 only if `w_v`=1.
- When `cdb_v_o`=0, `cdb_o` = '0. Physical register 0 is never a rename destination, so an idle CDB never matches a waiting source tag.
- `flush_i`=1 at a rising edge:
  - Clears every stage valid, including the instruction presented in that same cycle.
  - Outputs in the following cycle are all 0.
  - Payload registers need not be cleared.

## Timing
- Accept at edge T; `cdb_v_o`/`rob_done_v_o` are high during cycle T+`MUL_STAGES`-1. With the default of 3, that is the second cycle after the accept edge.
- Throughput is 1 per cycle. Back-to-back accepts produce back-to-back broadcasts in the same order.
- All outputs come straight from registers; there is no combinational path from any input to any output.
- Reset: all stage valids = 0; `cdb_o`='0, `cdb_v_o`=0, `rob_done_v_o`=0, `rob_idx_o`=0 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight work, with no broadcast.
- Flush and reset act identically on valids. Reset has priority over `flush_i`.
- The first accept is legal on the first edge with `reset_i`=1.

## Structure
- `Purple_Jade_pkg` holds:
  - `WORD_SIZE_P`, `NUM_PHYS_REG`, `ROB_ENTRY`, `MUL_FU` index.
  - `issued_instruction_t`, `CDB_t`.
  - Multiply opcode constants (MUL/MULH/MULHU).
  - `mul_op_e` enum.
- One sub-module, `mul_pipe_core`:
  - Inputs: two operands and a signed flag.
  - Output: `2*WORD_SIZE_P` product after `MUL_STAGES-1` register stages.
  - Parameterized on `MUL_STAGES` and width.
- The top level handles metadata pipelining, flush, half-select and output registers.

## Test plan
- Reset: hold `reset_i`=0 for 3 cycles while driving `valid_i`=1 -> all outputs 0 throughout and one cycle after release; no broadcast ever appears for those inputs.
- Basic MUL: 16-bit, 0x0007×0xFFFD, `dest_id`=5, `rob_dest`=2, `w_v`=1 -> two cycles later `cdb_v_o`=1, `dest`=5, `result`=0xFFEB, `rob_done_v_o`=1, `rob_idx_o`=2; idle the next cycle.
- High halves: 0x8000×0x8000 -> MULH gives 0x4000, MULHU gives 0x4000; 0xFFFF×0xFFFF -> MULH gives 0x0000, MULHU gives 0xFFFE.
- Streaming: 10 consecutive accepts with distinct dests 1..10 -> 10 consecutive broadcasts, in order, with correct products and no gaps.
- Flush: accept A, B, C on consecutive edges and assert `flush_i` with C -> no broadcast for A, B or C. D accepted the edge after the flush broadcasts normally.
- `w_v`=0: MUL with `w_v`=0, `rob_dest`=7 -> `rob_done_v_o`=1, `rob_idx_o`=7, `cdb_v_o`=0, `cdb_o`='0.
